// File: rtl/led_fader.sv
// Four-channel LED driver: a set input bit lights its LED solidly; when the bit
// clears, the LED dims linearly through a PWM duty ramp paced by a prescaler.
module led_fader #(
  parameter int NP = 16,
  parameter int PW = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [3:0]        din,
  output logic [3:0]        leds,
  output logic [4*PW-1:0]   lvl,
  output logic              busy
);

  localparam logic [PW-1:0] LVL_MAX = '1;

  logic [3:0]           din_q;
  logic [NP-1:0]        pre_q, pre_d;
  logic [PW-1:0]        pc_q, pc_d;
  logic [3:0][PW-1:0]   lvl_q, lvl_d;
  logic [3:0]           leds_q, leds_d;
  logic                 tick;

  always_comb begin
    pre_d  = pre_q + 1'b1;
    pc_d   = pc_q + 1'b1;
    tick   = &pre_q;
    busy   = 1'b0;
    lvl_d  = lvl_q;
    leds_d = '0;
    for (int i = 0; i < 4; i++) begin
      // A held-on input reloads full brightness even on a tick cycle.
      if (din_q[i]) begin
        lvl_d[i] = LVL_MAX;
      end else if (tick && (lvl_q[i] != '0)) begin
        lvl_d[i] = lvl_q[i] - 1'b1;
      end
      leds_d[i] = din_q[i] | (pc_q < lvl_q[i]);
      busy      = busy | (~din_q[i] & (lvl_q[i] != '0));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din_q  <= '0;
      pre_q  <= '0;
      pc_q   <= '0;
      lvl_q  <= '0;
      leds_q <= '0;
    end else begin
      din_q  <= din;
      pre_q  <= pre_d;
      pc_q   <= pc_d;
      lvl_q  <= lvl_d;
      leds_q <= leds_d;
    end
  end

  assign leds = leds_q;
  assign lvl  = lvl_q;

endmodule
